// File: rtl/toy_pack.sv
// toy_pack: shared constants and types for the instruction-cache downstream path.
package toy_pack;
    localparam int MSHR_ENTRY_NUM               = 8;
    localparam int MSHR_ENTRY_INDEX_WIDTH       = $clog2(MSHR_ENTRY_NUM);
    localparam int ICACHE_DOWNSTREAM_DATA_WIDTH = 512;
    localparam int REQ_ADDR_WIDTH               = 32;
    localparam int TXNID_WIDTH                  = 8;
    localparam int OPCODE_WIDTH                 = 4;

    localparam logic [OPCODE_WIDTH-1:0] DOWNSTREAM_OPCODE = 4'h4;

    typedef logic [REQ_ADDR_WIDTH-1:0] req_addr_t;

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0] opcode;
        logic [TXNID_WIDTH-1:0]  txnid;
        req_addr_t               addr;
    } downstream_txreq_t;

    typedef struct packed {
        logic [TXNID_WIDTH-1:0]                  txnid;
        logic [ICACHE_DOWNSTREAM_DATA_WIDTH-1:0] data;
    } downstream_rxdat_t;

    typedef enum logic { ARB_IDLE, ARB_ISSUE } arb_state_e;
endpackage

// File: rtl/icache_rr_arb.sv
// icache_rr_arb: combinational round-robin arbiter; the search begins at ptr and wraps.
module icache_rr_arb #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    logic [IW-1:0] k;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < N; i++) begin
            k = IW'((int'(ptr) + i) % N);
            if (!found && req[k]) begin
                gnt[k] = 1'b1;
                found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/icache_downstream_arb.sv
// icache_downstream_arb: picks MSHR misses round-robin onto the downstream request channel
// and routes refill beats back through a one-entry fill buffer.
module icache_downstream_arb #(
    parameter int MSHR_ENTRY_NUM = toy_pack::MSHR_ENTRY_NUM,
    parameter int DATA_WIDTH     = toy_pack::ICACHE_DOWNSTREAM_DATA_WIDTH
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [MSHR_ENTRY_NUM-1:0]                  entry_req_vld,
    input  toy_pack::req_addr_t                        entry_req_addr [MSHR_ENTRY_NUM],
    output logic [MSHR_ENTRY_NUM-1:0]                  entry_req_gnt,
    output logic                                       downstream_txreq_vld,
    input  logic                                       downstream_txreq_rdy,
    output toy_pack::downstream_txreq_t                downstream_txreq_pld,
    input  logic                                       downstream_rxdat_vld,
    output logic                                       downstream_rxdat_rdy,
    input  toy_pack::downstream_rxdat_t                downstream_rxdat_pld,
    output logic                                       fill_vld,
    input  logic                                       fill_rdy,
    output logic [toy_pack::MSHR_ENTRY_INDEX_WIDTH-1:0] fill_entry_idx,
    output logic [DATA_WIDTH-1:0]                      fill_data,
    output logic [MSHR_ENTRY_NUM-1:0]                  outstanding,
    output logic                                       err_unexp_rxdat
);
    import toy_pack::*;

    localparam int IW = MSHR_ENTRY_INDEX_WIDTH;
    localparam logic [MSHR_ENTRY_NUM-1:0] ONE = MSHR_ENTRY_NUM'(1);

    arb_state_e                state_q, state_d;
    downstream_txreq_t         pld_q, pld_d;
    logic [IW-1:0]             rr_ptr_q, rr_ptr_d, buf_idx_q, buf_idx_d, win_idx;
    logic [MSHR_ENTRY_NUM-1:0] out_q, out_d, held, elig, win_gnt, fill_clr;
    logic                      buf_vld_q, buf_vld_d, err_q, err_d;
    logic [DATA_WIDTH-1:0]     buf_data_q, buf_data_d;
    logic                      tx_hs, rx_hs, rx_ok, fill_hs, load;

    icache_rr_arb #(.N(MSHR_ENTRY_NUM), .IW(IW)) u_rr_arb (
        .req (elig),
        .ptr (rr_ptr_q),
        .gnt (win_gnt)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < MSHR_ENTRY_NUM; i++) win_idx = win_gnt[i] ? IW'(i) : win_idx;
    end

    always_comb begin
        tx_hs    = (state_q == ARB_ISSUE) && downstream_txreq_rdy;
        load     = (state_q == ARB_IDLE) || tx_hs;
        // The held entry is excluded so it is never re-picked on its own handshake cycle.
        held     = (state_q == ARB_ISSUE) ? ONE << pld_q.txnid[IW-1:0] : '0;
        elig     = entry_req_vld & ~out_q & ~held;
        state_d  = load ? (|elig ? ARB_ISSUE : ARB_IDLE) : state_q;
        rr_ptr_d = (load && |elig) ? IW'((int'(win_idx) + 1) % MSHR_ENTRY_NUM) : rr_ptr_q;
        pld_d    = pld_q;
        if (load && |elig) begin
            pld_d.opcode = DOWNSTREAM_OPCODE;
            pld_d.txnid  = TXNID_WIDTH'(win_idx);
            pld_d.addr   = entry_req_addr[win_idx];
        end
        fill_hs    = buf_vld_q && fill_rdy;
        rx_hs      = downstream_rxdat_vld && (!buf_vld_q || fill_rdy);
        rx_ok      = (downstream_rxdat_pld.txnid < TXNID_WIDTH'(MSHR_ENTRY_NUM))
                     && out_q[downstream_rxdat_pld.txnid[IW-1:0]];
        fill_clr   = fill_hs ? ONE << buf_idx_q : '0;
        out_d      = (out_q | (tx_hs ? held : '0)) & ~fill_clr;
        buf_vld_d  = (rx_hs && rx_ok) || (buf_vld_q && !fill_rdy);
        buf_idx_d  = (rx_hs && rx_ok) ? downstream_rxdat_pld.txnid[IW-1:0] : buf_idx_q;
        buf_data_d = (rx_hs && rx_ok) ? downstream_rxdat_pld.data[DATA_WIDTH-1:0] : buf_data_q;
        err_d      = err_q || (rx_hs && !rx_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            pld_q      <= '0;
            rr_ptr_q   <= '0;
            out_q      <= '0;
            buf_vld_q  <= 1'b0;
            buf_idx_q  <= '0;
            buf_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pld_q      <= pld_d;
            rr_ptr_q   <= rr_ptr_d;
            out_q      <= out_d;
            buf_vld_q  <= buf_vld_d;
            buf_idx_q  <= buf_idx_d;
            buf_data_q <= buf_data_d;
            err_q      <= err_d;
        end
    end

    assign entry_req_gnt        = tx_hs ? held : '0;
    assign downstream_txreq_vld = (state_q == ARB_ISSUE);
    assign downstream_txreq_pld = pld_q;
    assign downstream_rxdat_rdy = !buf_vld_q || fill_rdy;
    assign fill_vld             = buf_vld_q;
    assign fill_entry_idx       = buf_idx_q;
    assign fill_data            = buf_data_q;
    assign outstanding          = out_q;
    assign err_unexp_rxdat      = err_q;
endmodule

// File: tb/tb_icache_downstream_arb.sv
// tb_icache_downstream_arb: directed vector table, hand-written corner sequences and
// randomized traffic checked against a transaction-level model of the arbiter.
module tb_icache_downstream_arb;
    import toy_pack::*;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]      req_vld, gnt, outst;
    req_addr_t         req_addr [N];
    logic              tx_vld, tx_rdy, rx_vld, rx_rdy, fill_vld, fill_rdy, err;
    downstream_txreq_t tx_pld;
    downstream_rxdat_t rx_pld;
    logic [2:0]        fill_idx;
    logic [511:0]      fill_data;

    icache_downstream_arb #(.MSHR_ENTRY_NUM(N), .DATA_WIDTH(512)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .entry_req_vld        (req_vld),
        .entry_req_addr       (req_addr),
        .entry_req_gnt        (gnt),
        .downstream_txreq_vld (tx_vld),
        .downstream_txreq_rdy (tx_rdy),
        .downstream_txreq_pld (tx_pld),
        .downstream_rxdat_vld (rx_vld),
        .downstream_rxdat_rdy (rx_rdy),
        .downstream_rxdat_pld (rx_pld),
        .fill_vld             (fill_vld),
        .fill_rdy             (fill_rdy),
        .fill_entry_idx       (fill_idx),
        .fill_data            (fill_data),
        .outstanding          (outst),
        .err_unexp_rxdat      (err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model: one held request, a set of outstanding entries, one fill slot.
    bit           m_issue;
    int           m_idx, m_ptr, m_bidx;
    logic [31:0]  m_addr;
    bit [N-1:0]   m_out;
    bit           m_bv, m_err;
    logic [511:0] m_bdata;

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic       exp_vld;
        logic [7:0] exp_txnid;
        logic [7:0] exp_gnt;
        logic [7:0] exp_out;
    } vec_t;

    vec_t       vt [4];
    logic [7:0] obs [$];
    int         pend [$];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_issue = 0; m_idx = 0; m_ptr = 0; m_bidx = 0; m_addr = '0;
        m_out = '0; m_bv = 0; m_err = 0; m_bdata = '0;
    endtask

    task automatic check_outputs();
        chk("txreq_vld", tx_vld, m_issue);
        if (m_issue) begin
            chk("txnid", tx_pld.txnid, m_idx);
            chk("txaddr", tx_pld.addr, m_addr);
            chk("opcode", tx_pld.opcode, DOWNSTREAM_OPCODE);
        end
        chk("gnt", gnt, (m_issue && tx_rdy) ? (8'd1 << m_idx) : 8'd0);
        chk("outstanding", outst, m_out);
        chk("rxdat_rdy", rx_rdy, !m_bv || fill_rdy);
        chk("fill_vld", fill_vld, m_bv);
        if (m_bv) begin
            chk("fill_idx", fill_idx, m_bidx);
            chk("fill_data", fill_data, m_bdata);
        end
        chk("err", err, m_err);
    endtask

    task automatic model_advance();
        bit hs, fhs, rhs, ok;
        bit [N-1:0] nout;
        int w;
        hs   = m_issue && tx_rdy;
        fhs  = m_bv && fill_rdy;
        rhs  = rx_vld && (!m_bv || fill_rdy);
        ok   = (rx_pld.txnid < N) && m_out[rx_pld.txnid[2:0]];
        nout = m_out;
        if (hs) nout[m_idx] = 1;
        if (fhs) nout[m_bidx] = 0;
        if (!m_issue || hs) begin
            w = -1;
            for (int j = 0; j < N; j++) begin
                int k;
                k = (m_ptr + j) % N;
                if (w < 0 && req_vld[k] && !m_out[k] && !(m_issue && m_idx == k)) w = k;
            end
            m_issue = (w >= 0);
            if (w >= 0) begin
                m_idx  = w;
                m_addr = req_addr[w];
                m_ptr  = (w + 1) % N;
            end
        end
        if (rhs && ok) begin
            m_bv    = 1;
            m_bidx  = int'(rx_pld.txnid);
            m_bdata = rx_pld.data;
        end else if (fhs) begin
            m_bv = 0;
        end
        if (rhs && !ok) m_err = 1;
        m_out = nout;
    endtask

    task automatic step();
        #1;
        check_outputs();
        model_advance();
        @(negedge clk);
    endtask

    initial begin
        req_vld = '0; tx_rdy = 0; rx_vld = 0; rx_pld = '0; fill_rdy = 1;
        for (int i = 0; i < N; i++) req_addr[i] = 32'h1000 + 32'(i * 64);
        model_reset();
        repeat (2) @(negedge clk);
        #1 check_outputs();
        rst_n = 1;
        @(negedge clk);

        // Two requesters from reset: entry 0 then 2 on consecutive cycles.
        vt[0] = '{8'h05, 1'b1, 1'b0, 8'd0, 8'h00, 8'h00};
        vt[1] = '{8'h05, 1'b1, 1'b1, 8'd0, 8'h01, 8'h00};
        vt[2] = '{8'h05, 1'b1, 1'b1, 8'd2, 8'h04, 8'h01};
        vt[3] = '{8'h05, 1'b1, 1'b0, 8'd0, 8'h00, 8'h05};
        for (int i = 0; i < 4; i++) begin
            req_vld = vt[i].req;
            tx_rdy  = vt[i].rdy;
            #1;
            chk("vec_vld", tx_vld, vt[i].exp_vld);
            if (vt[i].exp_vld) chk("vec_txnid", tx_pld.txnid, vt[i].exp_txnid);
            chk("vec_gnt", gnt, vt[i].exp_gnt);
            chk("vec_out", outst, vt[i].exp_out);
            step();
        end

        // Back-pressured request keeps its captured address.
        req_vld = 8'h08; tx_rdy = 0; req_addr[3] = 32'hDEAD_0000;
        step();
        req_addr[3] = 32'hBEEF_0040; req_vld = '0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("held_txnid", tx_pld.txnid, 8'd3);
            chk("held_addr", tx_pld.addr, 32'hDEAD_0000);
            step();
        end
        tx_rdy = 1;
        #1 chk("held_gnt", gnt, 8'h08);
        step();
        tx_rdy = 0;

        // Refill with a stalled consumer.
        fill_rdy = 0; rx_vld = 1; rx_pld.txnid = 8'd3; rx_pld.data = {16{32'hA5A5_A5A5}};
        step();
        rx_pld.txnid = 8'd0; rx_pld.data = {16{32'h0000_1111}};
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_rdy", rx_rdy, 1'b0);
            chk("stall_fill_idx", fill_idx, 3'd3);
            chk("stall_fill_data", fill_data, {16{32'hA5A5_A5A5}});
            step();
        end
        fill_rdy = 1;
        step();
        #1 chk("fill3_cleared", outst, 8'h05);
        rx_pld.txnid = 8'd2;
        step();
        rx_vld = 0;
        step();
        #1 chk("all_cleared", outst, 8'h00);

        // Unexpected refills: unknown entry, then an out-of-range txnid aliasing entry 1.
        rx_vld = 1; rx_pld.txnid = 8'd6;
        step();
        rx_vld = 0;
        #1;
        chk("unexp_no_fill", fill_vld, 1'b0);
        chk("unexp_err", err, 1'b1);
        repeat (3) step();
        #1 chk("err_sticky", err, 1'b1);
        req_vld = 8'h02; tx_rdy = 1;
        step(); step();
        req_vld = '0; tx_rdy = 0; rx_vld = 1; rx_pld.txnid = 8'd9;
        step();
        #1;
        chk("alias_no_fill", fill_vld, 1'b0);
        chk("alias_out", outst, 8'h02);
        rx_pld.txnid = 8'd1;
        step();
        rx_vld = 0;
        step();

        // Asynchronous reset with both a request and a fill pending.
        req_vld = 8'h20; tx_rdy = 1;
        step(); step();
        req_vld = 8'h40; tx_rdy = 0; fill_rdy = 0; rx_vld = 1; rx_pld.txnid = 8'd5;
        step();
        rx_vld = 0;
        #1;
        chk("pre_rst_tx_vld", tx_vld, 1'b1);
        chk("pre_rst_fill_vld", fill_vld, 1'b1);
        tx_rdy = 1;
        #2 rst_n = 0;
        #1;
        chk("rst_tx_vld", tx_vld, 1'b0);
        chk("rst_fill_vld", fill_vld, 1'b0);
        chk("rst_gnt", gnt, 8'h00);
        chk("rst_out", outst, 8'h00);
        chk("rst_err", err, 1'b0);
        model_reset();
        req_vld = '0; tx_rdy = 0; fill_rdy = 1;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Every entry requesting forever: strict rotation with immediate refills.
        req_vld = 8'hFF; tx_rdy = 1; obs.delete(); pend.delete();
        for (int c = 0; c < 20; c++) begin
            rx_vld = 0;
            if (pend.size() > 0) begin
                rx_vld = 1;
                rx_pld.txnid = 8'(pend.pop_front());
                rx_pld.data = {16{$urandom()}};
            end
            #1;
            for (int k = 0; k < N; k++) if (gnt[k]) pend.push_back(k);
            if (gnt != 0) obs.push_back(gnt);
            step();
        end
        chk("rr_grant_count", obs.size() >= 9, 1'b1);
        for (int i = 0; i < 9 && i < obs.size(); i++) chk("rr_order", obs[i], 8'd1 << (i % 8));
        req_vld = '0; tx_rdy = 0; rx_vld = 0;
        while (pend.size() > 0) begin
            rx_vld = 1;
            rx_pld.txnid = 8'(pend.pop_front());
            step();
        end
        rx_vld = 0;
        repeat (3) step();

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            req_vld = 8'($urandom());
            if ($urandom_range(0, 3) == 0) req_addr[$urandom_range(0, N - 1)] = $urandom();
            tx_rdy   = ($urandom_range(0, 2) != 0);
            fill_rdy = ($urandom_range(0, 3) != 0);
            rx_vld   = 0;
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 19) == 0) begin
                    rx_vld = 1;
                    rx_pld.txnid = 8'($urandom_range(0, 15));
                end else if (m_out != 0) begin
                    int k;
                    k = $urandom_range(0, N - 1);
                    while (!m_out[k]) k = (k + 1) % N;
                    rx_vld = 1;
                    rx_pld.txnid = 8'(k);
                end
            end
            rx_pld.data = {16{$urandom()}};
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
